// File: rtl/tx_huge_page_notify.sv
// rtl/tx_huge_page_notify.sv - sends one posted MWr TLP per filled huge page and pulses the matching done strobe
module tx_huge_page_notify (
  input  logic        trn_clk,
  input  logic        reset,
  input  logic        notify_1,
  input  logic        notify_2,
  input  logic [30:0] byte_cnt_1,
  input  logic [30:0] byte_cnt_2,
  input  logic [63:0] notify_addr,
  input  logic [15:0] cfg_completer_id,
  output logic        tx_req,
  input  logic        tx_grant,
  output logic [63:0] trn_td,
  output logic [7:0]  trn_trem_n,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  input  logic        trn_tdst_rdy_n,
  input  logic [3:0]  trn_tbuf_av,
  output logic        notify_done_1,
  output logic        notify_done_2,
  output logic        notify_overflow
);
  typedef enum logic [2:0] {IDLE, REQ, Q0, Q1, Q2, DONE} state_t;

  state_t      state;
  logic        pend_1, pend_2;
  logic [30:0] cnt_1, cnt_2;
  logic        page2;   // page being served is page 2
  logic        last2;   // page 2 was the last page selected
  logic [63:0] addr;
  logic        accept, last_acc, clr_1, clr_2, is64, pick2;
  logic [31:0] pay, swp;

  always_comb begin
    accept   = !trn_tsrc_rdy_n && !trn_tdst_rdy_n;
    is64     = (addr[63:32] != 32'h0);
    last_acc = accept && ((state == Q1 && !is64) || state == Q2);
    clr_1    = last_acc && !page2;
    clr_2    = last_acc && page2;
    pick2    = pend_2 && (!pend_1 || !last2);
    pay      = {page2, (page2 ? cnt_2 : cnt_1)};
    swp      = {pay[7:0], pay[15:8], pay[23:16], pay[31:24]};
  end

  // A notify in the clearing cycle re-arms the page instead of counting as an overflow.
  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) begin
      pend_1          <= 1'b0;
      pend_2          <= 1'b0;
      cnt_1           <= '0;
      cnt_2           <= '0;
      notify_overflow <= 1'b0;
    end else begin
      if (notify_1) begin
        if (pend_1 && !clr_1) begin
          notify_overflow <= 1'b1;
        end else begin
          pend_1 <= 1'b1;
          cnt_1  <= byte_cnt_1;
        end
      end else if (clr_1) begin
        pend_1 <= 1'b0;
      end
      if (notify_2) begin
        if (pend_2 && !clr_2) begin
          notify_overflow <= 1'b1;
        end else begin
          pend_2 <= 1'b1;
          cnt_2  <= byte_cnt_2;
        end
      end else if (clr_2) begin
        pend_2 <= 1'b0;
      end
    end
  end

  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      page2          <= 1'b0;
      last2          <= 1'b1;
      addr           <= '0;
      tx_req         <= 1'b0;
      trn_td         <= '0;
      trn_trem_n     <= 8'h00;
      trn_tsof_n     <= 1'b1;
      trn_teof_n     <= 1'b1;
      trn_tsrc_rdy_n <= 1'b1;
      notify_done_1  <= 1'b0;
      notify_done_2  <= 1'b0;
    end else begin
      notify_done_1 <= 1'b0;
      notify_done_2 <= 1'b0;
      case (state)
        IDLE: begin
          if (pend_1 || pend_2) begin
            state  <= REQ;
            tx_req <= 1'b1;
            page2  <= pick2;
            last2  <= pick2;
            addr   <= {notify_addr[63:2], 2'b00};
          end
        end
        REQ: begin
          if (tx_grant && trn_tbuf_av[1]) begin
            state          <= Q0;
            trn_td         <= {(is64 ? 32'h6000_0001 : 32'h4000_0001), cfg_completer_id, 8'h00, 8'h0F};
            trn_tsof_n     <= 1'b0;
            trn_teof_n     <= 1'b1;
            trn_trem_n     <= 8'h00;
            trn_tsrc_rdy_n <= 1'b0;
          end
        end
        Q0: begin
          if (accept) begin
            state      <= Q1;
            trn_tsof_n <= 1'b1;
            trn_teof_n <= is64;
            trn_td     <= is64 ? addr : {addr[31:0], swp};
          end
        end
        Q1: begin
          if (accept && is64) begin
            state      <= Q2;
            trn_td     <= {swp, 32'h0};
            trn_teof_n <= 1'b0;
            trn_trem_n <= 8'h0F;
          end
        end
        Q2:      state <= Q2;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // Last qword taken: drop the port and report the page in one step.
      if (last_acc) begin
        state          <= DONE;
        tx_req         <= 1'b0;
        trn_tsrc_rdy_n <= 1'b1;
        trn_teof_n     <= 1'b1;
        trn_trem_n     <= 8'h00;
        notify_done_1  <= !page2;
        notify_done_2  <= page2;
      end
    end
  end
endmodule

// File: tb/tb_tx_huge_page_notify.sv
// tb/tb_tx_huge_page_notify.sv - randomized self-checking bench for tx_huge_page_notify
module tb_tx_huge_page_notify;
  logic        trn_clk = 1'b0;
  logic        reset = 1'b1;
  logic        notify_1 = 1'b0, notify_2 = 1'b0;
  logic [30:0] byte_cnt_1 = '0, byte_cnt_2 = '0;
  logic [63:0] notify_addr = '0;
  logic [15:0] cfg_completer_id = '0;
  logic        tx_req, tx_grant = 1'b0;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n;
  logic        trn_tdst_rdy_n = 1'b1;
  logic [3:0]  trn_tbuf_av = 4'h0;
  logic        notify_done_1, notify_done_2, notify_overflow;

  tx_huge_page_notify dut (
    .trn_clk(trn_clk), .reset(reset), .notify_1(notify_1), .notify_2(notify_2),
    .byte_cnt_1(byte_cnt_1), .byte_cnt_2(byte_cnt_2), .notify_addr(notify_addr),
    .cfg_completer_id(cfg_completer_id), .tx_req(tx_req), .tx_grant(tx_grant),
    .trn_td(trn_td), .trn_trem_n(trn_trem_n), .trn_tsof_n(trn_tsof_n), .trn_teof_n(trn_teof_n),
    .trn_tsrc_rdy_n(trn_tsrc_rdy_n), .trn_tdst_rdy_n(trn_tdst_rdy_n), .trn_tbuf_av(trn_tbuf_av),
    .notify_done_1(notify_done_1), .notify_done_2(notify_done_2), .notify_overflow(notify_overflow)
  );

  always #5 trn_clk = ~trn_clk;

  int passed = 0, total = 0;
  int done_cnt_1 = 0, done_cnt_2 = 0, qw_acc = 0, tlp_cnt = 0;

  // reference model: pending pages, latched counts, last served page, sticky overflow
  bit          m_pend [1:2];
  logic [30:0] m_cnt [1:2];
  int          m_last;
  bit          m_ovf;
  logic [63:0] exp_q [0:2];
  int          exp_n;

  always @(negedge trn_clk) begin
    if (!reset) begin
      if (notify_done_1) done_cnt_1++;
      if (notify_done_2) done_cnt_2++;
      if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
        qw_acc++;
        if (!trn_tsof_n) tlp_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge trn_clk);
    #1;
  endtask

  task automatic model_reset();
    m_pend[1] = 0; m_pend[2] = 0; m_cnt[1] = '0; m_cnt[2] = '0; m_last = 2; m_ovf = 0;
  endtask

  task automatic build_exp(input int page, input logic [30:0] cnt);
    logic [31:0] p, s;
    logic [63:0] a;
    p = {1'b0, cnt};
    if (page == 2) p = p + 32'h8000_0000;
    s = ((p & 32'hFF) << 24) | (((p >> 8) & 32'hFF) << 16) | (((p >> 16) & 32'hFF) << 8) | (p >> 24);
    a = notify_addr & ~64'h3;
    if ((a >> 32) == 64'h0) begin
      exp_n = 2;
      exp_q[0] = {32'h4000_0001, cfg_completer_id, 16'h000F};
      exp_q[1] = (a << 32) | {32'h0, s};
    end else begin
      exp_n = 3;
      exp_q[0] = {32'h6000_0001, cfg_completer_id, 16'h000F};
      exp_q[1] = a;
      exp_q[2] = {s, 32'h0};
    end
  endtask

  task automatic pulse(input bit n1, input bit n2, input logic [30:0] c1, input logic [30:0] c2);
    notify_1 = n1; notify_2 = n2; byte_cnt_1 = c1; byte_cnt_2 = c2;
    step();
    notify_1 = 0; notify_2 = 0; byte_cnt_1 = 31'($urandom); byte_cnt_2 = 31'($urandom);
    if (n1) begin if (m_pend[1]) m_ovf = 1; else begin m_pend[1] = 1; m_cnt[1] = c1; end end
    if (n2) begin if (m_pend[2]) m_ovf = 1; else begin m_pend[2] = 1; m_cnt[2] = c2; end end
  endtask

  task automatic expect_tlp(input int page, input int bp_min, input int bp_max, input string nm);
    int w, hold, d1, d2, qa;
    logic e_sof, e_eof;
    logic [7:0] e_rem;
    build_exp(page, m_cnt[page]);
    d1 = done_cnt_1; d2 = done_cnt_2; qa = qw_acc;
    w = 0;
    while (tx_req !== 1'b1 && w < 100) begin step(); w++; end
    total++;
    if (tx_req !== 1'b1) $display("FAIL %s req: tx_req=%b required 1", nm, tx_req); else passed++;
    tx_grant = 1; trn_tbuf_av = 4'b0010; trn_tdst_rdy_n = 1;
    step();
    for (int k = 0; k < exp_n; k++) begin
      tx_grant = 1'($urandom_range(1, 0)); trn_tbuf_av = 4'($urandom_range(15, 0));
      hold = $urandom_range(bp_max, bp_min);
      e_sof = (k == 0) ? 1'b0 : 1'b1;
      e_eof = (k == exp_n - 1) ? 1'b0 : 1'b1;
      e_rem = (k == exp_n - 1 && exp_n == 3) ? 8'h0F : 8'h00;
      for (int h = 0; h <= hold; h++) begin
        trn_tdst_rdy_n = (h != hold);
        total++;
        if ({trn_td, trn_tsof_n, trn_teof_n, trn_trem_n, trn_tsrc_rdy_n, tx_req} !==
            {exp_q[k], e_sof, e_eof, e_rem, 1'b0, 1'b1})
          $display("FAIL %s qw%0d: td=%h sof=%b eof=%b rem=%h src=%b req=%b required td=%h sof=%b eof=%b rem=%h src=0 req=1",
                   nm, k, trn_td, trn_tsof_n, trn_teof_n, trn_trem_n, trn_tsrc_rdy_n, tx_req,
                   exp_q[k], e_sof, e_eof, e_rem);
        else passed++;
        step();
      end
    end
    trn_tdst_rdy_n = 1; tx_grant = 0; trn_tbuf_av = 4'h0;
    total++;
    if ({trn_tsrc_rdy_n, tx_req, notify_done_1, notify_done_2} !== {1'b1, 1'b0, page == 1, page == 2})
      $display("FAIL %s end: src=%b req=%b done1=%b done2=%b required src=1 req=0 done1=%b done2=%b",
               nm, trn_tsrc_rdy_n, tx_req, notify_done_1, notify_done_2, page == 1, page == 2);
    else passed++;
    step();
    total++;
    if ({done_cnt_1 - d1, done_cnt_2 - d2, qw_acc - qa} !== {(page == 1) ? 1 : 0, (page == 2) ? 1 : 0, exp_n})
      $display("FAIL %s counts: done1=%0d done2=%0d qw=%0d required done1=%0d done2=%0d qw=%0d",
               nm, done_cnt_1 - d1, done_cnt_2 - d2, qw_acc - qa, (page == 1) ? 1 : 0, (page == 2) ? 1 : 0, exp_n);
    else passed++;
    m_pend[page] = 0;
    m_last = page;
  endtask

  task automatic drain(input int bp_min, input int bp_max, input string nm);
    int pg;
    while (m_pend[1] || m_pend[2]) begin
      if (m_pend[1] && m_pend[2]) pg = (m_last == 1) ? 2 : 1;
      else pg = m_pend[1] ? 1 : 2;
      expect_tlp(pg, bp_min, bp_max, nm);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    step(); step();
    total++;
    if ({tx_req, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_trem_n, trn_td, notify_done_1, notify_done_2, notify_overflow} !==
        {1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 64'h0, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_values: req=%b src=%b sof=%b eof=%b rem=%h td=%h d1=%b d2=%b ovf=%b required 0 1 1 1 00 0 0 0 0",
               tx_req, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_trem_n, trn_td, notify_done_1, notify_done_2, notify_overflow);
    else passed++;
    reset = 0;
    model_reset();
    step();
  endtask

  task automatic test_mwr32();
    notify_addr = 64'h0000_0000_1234_5678; cfg_completer_id = 16'h0100;
    pulse(1, 0, 31'h100, 31'h0);
    total++;
    if (tx_req !== 1'b0) $display("FAIL mwr32 req_n1: tx_req=%b required 0", tx_req); else passed++;
    step();
    total++;
    if (tx_req !== 1'b1) $display("FAIL mwr32 req_n2: tx_req=%b required 1", tx_req); else passed++;
    build_exp(1, 31'h100);
    total++;
    if ({exp_q[0], exp_q[1]} !== {64'h40000001_0100000F, 64'h12345678_00010000})
      $display("FAIL mwr32 model: q0=%h q1=%h required 40000001_0100000f 12345678_00010000", exp_q[0], exp_q[1]);
    else passed++;
    expect_tlp(1, 0, 0, "mwr32");
  endtask

  task automatic test_mwr64();
    notify_addr = 64'h0000_0001_8000_0000;
    pulse(0, 1, 31'h0, 31'h40);
    expect_tlp(2, 0, 0, "mwr64");
  endtask

  task automatic test_backpressure();
    cfg_completer_id = 16'hABCD;
    notify_addr = 64'h0000_0000_0000_1003;
    pulse(1, 0, 31'h1234_5678, 31'h0);
    expect_tlp(1, 3, 3, "bp32");
    notify_addr = 64'hFFFF_0000_0000_0040;
    pulse(0, 1, 31'h0, 31'h7FFF_FFFF);
    expect_tlp(2, 3, 3, "bp64");
  endtask

  task automatic test_gating();
    int w;
    bit bad;
    notify_addr = 64'h0000_0000_2000_0000;
    pulse(0, 1, 31'h0, 31'h55);
    w = 0;
    while (tx_req !== 1'b1 && w < 20) begin step(); w++; end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tx_grant = (i < 10); trn_tbuf_av = (i < 10) ? 4'b1101 : 4'b0010;
      step();
      if (tx_req !== 1'b1 || trn_tsrc_rdy_n !== 1'b1) bad = 1;
    end
    total++;
    if (bad) $display("FAIL gating: req=%b src=%b required req=1 src=1 throughout", tx_req, trn_tsrc_rdy_n);
    else passed++;
    expect_tlp(2, 0, 1, "gating");
  endtask

  task automatic test_round_robin_overflow();
    int t0;
    bit req_seen;
    notify_addr = 64'h0000_0000_0000_8000;
    t0 = tlp_cnt;
    pulse(1, 1, 31'h111, 31'h222);
    pulse(1, 0, 31'h333, 31'h0);
    total++;
    if (notify_overflow !== m_ovf) $display("FAIL rr overflow_set: ovf=%b required %b", notify_overflow, m_ovf);
    else passed++;
    expect_tlp(1, 0, 1, "rr_first");
    expect_tlp(2, 0, 1, "rr_second");
    req_seen = 0;
    for (int i = 0; i < 20; i++) begin step(); if (tx_req !== 1'b0) req_seen = 1; end
    total++;
    if (req_seen || tlp_cnt - t0 != 2) $display("FAIL rr tlp_count: tlps=%0d extra_req=%b required 2 and 0", tlp_cnt - t0, req_seen);
    else passed++;
    total++;
    if (notify_overflow !== 1'b1) $display("FAIL rr overflow_sticky: ovf=%b required 1", notify_overflow);
    else passed++;
  endtask

  task automatic test_random();
    bit n1, n2;
    for (int it = 0; it < 20; it++) begin
      notify_addr = {($urandom_range(1, 0) != 0) ? $urandom : 32'h0, $urandom};
      cfg_completer_id = 16'($urandom);
      n1 = 1'($urandom_range(1, 0));
      n2 = n1 ? 1'($urandom_range(1, 0)) : 1'b1;
      pulse(n1, n2, 31'($urandom), 31'($urandom));
      drain(0, 2, "random");
    end
  endtask

  task automatic test_reset_mid_tlp();
    int w, d1, d2;
    notify_addr = 64'h0000_0000_4444_0000;
    pulse(1, 0, 31'h99, 31'h0);
    w = 0;
    while (tx_req !== 1'b1 && w < 20) begin step(); w++; end
    tx_grant = 1; trn_tbuf_av = 4'b0010; trn_tdst_rdy_n = 1;
    step();
    trn_tdst_rdy_n = 0;
    step();
    trn_tdst_rdy_n = 1;
    d1 = done_cnt_1; d2 = done_cnt_2;
    #2 reset = 1;
    #1;
    total++;
    if ({tx_req, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_trem_n, trn_td, notify_done_1, notify_done_2, notify_overflow} !==
        {1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 64'h0, 1'b0, 1'b0, 1'b0})
      $display("FAIL mid_reset values: req=%b src=%b sof=%b eof=%b rem=%h td=%h d1=%b d2=%b ovf=%b required 0 1 1 1 00 0 0 0 0",
               tx_req, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_trem_n, trn_td, notify_done_1, notify_done_2, notify_overflow);
    else passed++;
    tx_grant = 0; trn_tbuf_av = 4'h0;
    step(); step();
    reset = 0;
    model_reset();
    for (int i = 0; i < 5; i++) step();
    total++;
    if (done_cnt_1 != d1 || done_cnt_2 != d2 || tx_req !== 1'b0)
      $display("FAIL mid_reset no_done: done1=%0d done2=%0d req=%b required %0d %0d 0",
               done_cnt_1, done_cnt_2, tx_req, d1, d2);
    else passed++;
    pulse(1, 1, 31'h0ABC, 31'h0DEF);
    drain(0, 1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_mwr32();
    test_mwr64();
    test_backpressure();
    test_gating();
    test_round_robin_overflow();
    test_random();
    test_reset_mid_tlp();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
